// File: rtl/iter_mac_unit.sv
// iter_mac_unit: iterative shift-add multiply-accumulate unit, one multiplier bit per cycle.
//
// Each operation takes DATA_W cycles in BUSY. The product is added to the running accumulator,
// or replaces it, and the result saturates to ACC_W bits. A valid/ready handshake is used on
// both the operand side and the result side.
//
// Ports:
//   clk_i        clock, rising edge
//   reset_i      synchronous active-high reset; aborts any operation in flight
//   in_valid_i   operand pair valid
//   in_ready_o   unit can accept operands (IDLE only)
//   a_i, b_i     multiplicand / multiplier
//   acc_en_i     1: accumulate product, 0: accumulator := product
//   clear_i      zero accumulator and overflow flag (IDLE only, takes effect before an accept)
//   out_valid_o  result_o valid
//   out_ready_i  downstream accepts result
//   result_o     accumulator value after the last operation (held after hand-off)
//   overflow_o   sticky saturation flag since last clear/reset
module iter_mac_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 2 * DATA_W + 4,
  parameter bit          SIGNED = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              acc_en_i,
  input  logic              clear_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ACC_W-1:0]  result_o,
  output logic              overflow_o
);

  localparam int unsigned ProdW = 2 * DATA_W;
  localparam int unsigned CntW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic [ProdW-1:0]  mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [ProdW-1:0]  prod_q;
  logic              neg_q;
  logic              acc_en_q;
  logic [CntW-1:0]   cnt_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  result_q;
  logic              out_valid_q;
  logic              ovf_q;

  // Operand magnitudes; DATA_W-bit unsigned so the most negative value maps to 2^(DATA_W-1).
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;

  // Final-iteration datapath; one extra bit over ACC_W lets the clamp detect any overflow.
  logic [ProdW-1:0]  prod_nxt;
  logic [ACC_W:0]    prod_ext;
  logic [ACC_W:0]    prod_sgn;
  logic [ACC_W:0]    acc_ext;
  logic [ACC_W:0]    sum;
  logic              sat_hit;
  logic [ACC_W-1:0]  sat_val;
  logic [ACC_W-1:0]  new_acc;

  always_comb begin
    a_neg = SIGNED && a_i[DATA_W-1];
    b_neg = SIGNED && b_i[DATA_W-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
  end

  always_comb begin
    prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
    prod_ext = {{(ACC_W + 1 - ProdW){1'b0}}, prod_nxt};
    prod_sgn = neg_q ? -prod_ext : prod_ext;
    acc_ext  = {(SIGNED ? acc_q[ACC_W-1] : 1'b0), acc_q};
    sum      = (acc_en_q ? acc_ext : '0) + prod_sgn;
    if (SIGNED) begin
      // Top two bits disagree -> the value does not fit in ACC_W signed bits.
      sat_hit = sum[ACC_W] ^ sum[ACC_W-1];
      sat_val = sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
    end else begin
      sat_hit = sum[ACC_W];
      sat_val = '1;
    end
    new_acc = sat_hit ? sat_val : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      neg_q       <= 1'b0;
      acc_en_q    <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // The accepted op reads acc_q only at the end of BUSY, so a same-cycle clear
          // is naturally seen first.
          if (clear_i) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
          end
          if (in_valid_i) begin
            mcand_q  <= {{DATA_W{1'b0}}, a_mag};
            mplier_q <= b_mag;
            prod_q   <= '0;
            neg_q    <= a_neg ^ b_neg;
            acc_en_q <= acc_en_i;
            cnt_q    <= '0;
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          prod_q   <= prod_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            acc_q       <= new_acc;
            result_q    <= new_acc;
            if (sat_hit) ovf_q <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign overflow_o  = ovf_q;

endmodule
